// File: rtl/freelist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : freelist_ctrl_if
//  Purpose  : Groups the rename-side alloc handshake, the ROB commit release
//             path, the flush strobe and the status outputs of the physical
//             register free list.
//  Ports    : master - rename/ROB side (drives alloc_req, commit_*, flush)
//             slave  - free-list controller (drives alloc_ready, alloc_preg,
//                      init_done, free_count)
//  Revision : 1.0 - initial release
// ============================================================================
interface freelist_ctrl_if #(
    parameter int PREG_W = 6,
    parameter int CNT_W  = 6
);
    logic              alloc_req;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc_preg;
    logic              commit_valid;
    logic [PREG_W-1:0] commit_old_preg;
    logic              flush;
    logic              init_done;
    logic [CNT_W-1:0]  free_count;

    modport master (
        output alloc_req,
        output commit_valid,
        output commit_old_preg,
        output flush,
        input  alloc_ready,
        input  alloc_preg,
        input  init_done,
        input  free_count
    );

    modport slave (
        input  alloc_req,
        input  commit_valid,
        input  commit_old_preg,
        input  flush,
        output alloc_ready,
        output alloc_preg,
        output init_done,
        output free_count
    );
endinterface
`default_nettype wire

// File: rtl/freelist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : freelist_ctrl
//  Purpose  : Physical-register free list for the rename stage. Hands out free
//             pregs from a speculative head, takes back stale pregs at ROB
//             commit, and restores the speculative head from the committed
//             head on flush in a single cycle. After reset the storage is
//             filled serially with pregs NUM_AREGS..NUM_PREGS-1.
//  Ports    : clk - clock
//             rst - asynchronous active-high reset
//             fl  - freelist_ctrl_if.slave (alloc / commit / flush / status)
//  Revision : 1.0 - initial release
// ============================================================================
module freelist_ctrl #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    freelist_ctrl_if.slave  fl
);
    // DEPTH must be a power of two (>= 2) so the pointer index bits wrap
    // naturally and the extra MSB acts as the wrap bit.
    localparam int c_depth  = NUM_PREGS - NUM_AREGS;
    localparam int c_preg_w = $clog2(NUM_PREGS);
    localparam int c_idx_w  = $clog2(c_depth);
    localparam int c_ptr_w  = c_idx_w + 1;

    localparam logic [c_ptr_w-1:0]  c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_full = c_ptr_w'(c_depth);
    localparam logic [c_idx_w-1:0]  c_idx_one  = c_idx_w'(1);
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(c_depth - 1);
    localparam logic [c_preg_w-1:0] c_preg_base = c_preg_w'(NUM_AREGS);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state,       w_state_nxt;
    logic [c_idx_w-1:0]   r_fill_idx,    w_fill_idx_nxt;
    logic [c_ptr_w-1:0]   r_spec_head,   w_spec_head_nxt;
    logic [c_ptr_w-1:0]   r_commit_head, w_commit_head_nxt;
    logic [c_ptr_w-1:0]   r_tail,        w_tail_nxt;

    logic [c_preg_w-1:0]  r_mem [c_depth];

    logic                 w_mem_we;
    logic [c_idx_w-1:0]   w_mem_waddr;
    logic [c_preg_w-1:0]  w_mem_wdata;
    logic [c_ptr_w-1:0]   w_free_count;
    logic                 w_alloc_ready;
    logic                 w_init_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_fill_idx    <= '0;
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_idx    <= w_fill_idx_nxt;
            r_spec_head   <= w_spec_head_nxt;
            r_commit_head <= w_commit_head_nxt;
            r_tail        <= w_tail_nxt;
        end
    end

    // Storage has no reset: every entry is rewritten during INIT before use.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_fill_idx_nxt    = r_fill_idx;
        w_spec_head_nxt   = r_spec_head;
        w_commit_head_nxt = r_commit_head;
        w_tail_nxt        = r_tail;
        w_mem_we          = 1'b0;
        w_mem_waddr       = r_fill_idx;
        w_mem_wdata       = c_preg_base + c_preg_w'(r_fill_idx);
        w_init_done       = 1'b0;
        w_alloc_ready     = 1'b0;
        // Pointers are both zero during INIT, so this reads 0 there.
        w_free_count      = r_tail - r_spec_head;

        case (r_state)
            ST_INIT: begin
                w_mem_we       = 1'b1;
                w_fill_idx_nxt = r_fill_idx + c_idx_one;
                if (r_fill_idx == c_idx_last) begin
                    // List is full: tail sits one lap ahead of both heads.
                    w_tail_nxt  = c_ptr_full;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_init_done   = 1'b1;
                w_alloc_ready = (w_free_count != '0) && !fl.flush;
                if (fl.commit_valid) begin
                    w_mem_we          = 1'b1;
                    w_mem_waddr       = r_tail[c_idx_w-1:0];
                    w_mem_wdata       = fl.commit_old_preg;
                    w_tail_nxt        = r_tail + c_ptr_one;
                    w_commit_head_nxt = r_commit_head + c_ptr_one;
                end
                // Flush restores from the post-commit committed head so a
                // same-cycle retirement is not lost.
                if (fl.flush) begin
                    w_spec_head_nxt = w_commit_head_nxt;
                end else if (fl.alloc_req && w_alloc_ready) begin
                    w_spec_head_nxt = r_spec_head + c_ptr_one;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign fl.alloc_ready = w_alloc_ready;
    assign fl.alloc_preg  = r_mem[r_spec_head[c_idx_w-1:0]];
    assign fl.init_done   = w_init_done;
    assign fl.free_count  = w_free_count;

endmodule
`default_nettype wire

// File: tb/tb_freelist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freelist_ctrl
//  Purpose  : Directed self-checking bench for freelist_ctrl: init fill,
//             drain, commit refill, flush restore, steady alloc+commit with
//             wrap, and reset during INIT and RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freelist_ctrl;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int DEPTH     = 32;
    localparam int PREG_W    = 6;
    localparam int CNT_W     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    freelist_ctrl_if #(.PREG_W(PREG_W), .CNT_W(CNT_W)) fl ();

    freelist_ctrl #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_AREGS (NUM_AREGS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Waits (bounded) for init_done after reset release; fill takes DEPTH cycles.
    task automatic wait_init(input string tag);
        int cyc = 0;
        while (fl.init_done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_init_cycles"}, cyc, DEPTH);
        chk({tag, "_init_free"},   fl.free_count, DEPTH);
        chk({tag, "_init_preg"},   fl.alloc_preg, NUM_AREGS);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Always-on property checks while not in reset.
    always begin
        @(negedge clk); #2;
        if (!done && !rst) begin
            chk("mon_free_le_depth", (fl.free_count <= DEPTH), 1);
            if (fl.alloc_ready === 1'b1)
                chk("mon_ready_nonzero", (fl.free_count != 0), 1);
            if (fl.init_done !== 1'b1)
                chk("mon_no_ready_before_init", fl.alloc_ready, 0);
        end
    end

    logic [PREG_W-1:0] q[$];
    logic [PREG_W-1:0] old_v;
    logic [PREG_W-1:0] diff;

    initial begin
        fl.alloc_req       = 1'b0;
        fl.commit_valid    = 1'b0;
        fl.commit_old_preg = '0;
        fl.flush           = 1'b0;

        // ---- 1: reset state and init fill ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done",   fl.init_done, 0);
        chk("rst_alloc_ready", fl.alloc_ready, 0);
        chk("rst_free_count",  fl.free_count, 0);
        @(negedge clk); rst = 1'b0;
        wait_init("t1");
        chk("t1_ready", fl.alloc_ready, 1);

        // ---- 2: drain all 32 entries ----
        for (int i = 0; i < DEPTH; i++) begin
            fl.alloc_req = 1'b1;
            #1;
            chk("t2_preg",  fl.alloc_preg, NUM_AREGS + i);
            chk("t2_ready", fl.alloc_ready, 1);
            tick();
        end
        fl.alloc_req = 1'b0;
        #1;
        chk("t2_empty_ready", fl.alloc_ready, 0);
        chk("t2_empty_free",  fl.free_count, 0);
        fl.alloc_req = 1'b1;
        tick();
        fl.alloc_req = 1'b0;
        chk("t2_extra_free", fl.free_count, 0);
        chk("t2_extra_spec", dut.r_spec_head, 32);

        // ---- 3: commit into empty list, no bypass ----
        fl.commit_valid    = 1'b1;
        fl.commit_old_preg = 6'd5;
        #1;
        chk("t3_same_cycle_ready", fl.alloc_ready, 0);
        tick();
        fl.commit_valid = 1'b0;
        #1;
        chk("t3_next_ready", fl.alloc_ready, 1);
        chk("t3_next_preg",  fl.alloc_preg, 5);
        chk("t3_next_free",  fl.free_count, 1);

        // ---- 4: alloc 3, commit 1, flush ----
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_init("t4");
        for (int i = 0; i < 3; i++) begin
            fl.alloc_req = 1'b1;
            #1;
            chk("t4_alloc_preg", fl.alloc_preg, 32 + i);
            tick();
        end
        fl.alloc_req       = 1'b0;
        fl.commit_valid    = 1'b1;
        fl.commit_old_preg = 6'd7;
        tick();
        fl.commit_valid = 1'b0;
        fl.flush        = 1'b1;
        fl.alloc_req    = 1'b1;
        #1;
        chk("t4_flush_ready", fl.alloc_ready, 0);
        tick();
        fl.flush     = 1'b0;
        fl.alloc_req = 1'b0;
        #1;
        // After flush spec_head == commit_head, so the whole window is free
        // again: tail=33, spec_head=1.
        chk("t4_post_free", fl.free_count, DEPTH);
        chk("t4_post_preg", fl.alloc_preg, 33);
        chk("t4_tail",      dut.r_tail, 33);

        // Flush + commit in the same cycle: commit lands first.
        for (int i = 0; i < 2; i++) begin
            fl.alloc_req = 1'b1;
            #1;
            chk("t4b_alloc_preg", fl.alloc_preg, 33 + i);
            tick();
        end
        fl.alloc_req       = 1'b0;
        fl.commit_valid    = 1'b1;
        fl.commit_old_preg = 6'd9;
        fl.flush           = 1'b1;
        #1;
        chk("t4b_flush_ready", fl.alloc_ready, 0);
        tick();
        fl.commit_valid = 1'b0;
        fl.flush        = 1'b0;
        #1;
        chk("t4b_free",   fl.free_count, DEPTH);
        chk("t4b_preg",   fl.alloc_preg, 34);
        chk("t4b_commit", dut.r_commit_head, 2);
        chk("t4b_spec",   dut.r_spec_head, 2);

        // ---- 5: steady alloc+commit, 100 cycles with wrap ----
        // Free order from spec_head (idx 2): entries 2..31 hold 34..63,
        // entry 0 holds 7, entry 1 holds 9.
        q = {};
        for (int v = 34; v < 64; v++) q.push_back(PREG_W'(v));
        q.push_back(6'd7);
        q.push_back(6'd9);
        for (int i = 0; i < 100; i++) begin
            old_v              = PREG_W'((i * 5 + 3) % 64);
            fl.alloc_req       = 1'b1;
            fl.commit_valid    = 1'b1;
            fl.commit_old_preg = old_v;
            #1;
            chk("t5_preg",  fl.alloc_preg, q[0]);
            chk("t5_free",  fl.free_count, DEPTH);
            chk("t5_ready", fl.alloc_ready, 1);
            diff = dut.r_tail - dut.r_commit_head;
            chk("t5_tail_minus_commit", diff, DEPTH);
            void'(q.pop_front());
            q.push_back(old_v);
            tick();
        end
        fl.alloc_req    = 1'b0;
        fl.commit_valid = 1'b0;
        #1;
        chk("t5_end_free", fl.free_count, DEPTH);
        chk("t5_end_preg", fl.alloc_preg, q[0]);
        chk("t5_end_spec", dut.r_spec_head, 38);
        chk("t5_end_tail", dut.r_tail, 6);

        // ---- 6: reset mid-INIT and mid-RUN ----
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6a_fill_before", dut.r_fill_idx, 10);
        rst = 1'b1;
        #1;
        chk("t6a_init_done", fl.init_done, 0);
        chk("t6a_ready",     fl.alloc_ready, 0);
        chk("t6a_free",      fl.free_count, 0);
        chk("t6a_fill_idx",  dut.r_fill_idx, 0);
        @(negedge clk); rst = 1'b0;
        wait_init("t6a");

        for (int i = 0; i < 2; i++) begin
            fl.alloc_req = 1'b1;
            tick();
        end
        fl.alloc_req = 1'b0;
        #1;
        chk("t6b_preg_before", fl.alloc_preg, 34);
        rst = 1'b1;
        #1;
        chk("t6b_init_done", fl.init_done, 0);
        chk("t6b_ready",     fl.alloc_ready, 0);
        chk("t6b_free",      fl.free_count, 0);
        chk("t6b_spec",      dut.r_spec_head, 0);
        @(negedge clk); rst = 1'b0;
        wait_init("t6b");

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
